// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared fetch FSM state type and reset PC.
package hazard_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} fetch_state_t;
  localparam logic [31:0] RESET_PC = 32'h4000_0000;
endpackage

// File: rtl/register.sv
// register: enabled register with synchronous active-high reset to a fixed value.
module register #(
  parameter int W = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= RST_VAL;
    else if (en) q <= d;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF-stage fetch engine owning the PC, issuing held I-cache reads and buffering the word until commit.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = hazard_ctrl_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_read_i,
  input  logic        load_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        icache_read,
  output logic [31:0] icache_addr,
  input  logic        icache_resp,
  input  logic [31:0] icache_rdata,
  output logic        imem_resp,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);
  import hazard_ctrl_pkg::*;
  fetch_state_t state, state_n;
  logic [31:0] pc, pc_d, req_addr, instr_buf;
  logic pc_en, req_en, buf_en, commit;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = (imem_read_i && !redirect) ? REQ : IDLE;
      REQ:  state_n = redirect ? (icache_resp ? IDLE : DROP) : icache_resp ? (load_pc ? IDLE : HOLD) : REQ;
      HOLD: state_n = (redirect || load_pc) ? IDLE : HOLD;
      DROP: state_n = icache_resp ? IDLE : DROP;
      default: state_n = IDLE;
    endcase
  end
  // A redirect always wins over a commit, so a stale word never advances the PC.
  always_comb begin
    icache_read = state == REQ || state == DROP;
    icache_addr = req_addr;
    imem_resp   = !redirect && ((state == REQ && icache_resp) || state == HOLD);
    if_instr    = state == HOLD ? instr_buf : icache_rdata;
    if_pc       = (state == REQ || state == HOLD) ? req_addr : pc;
    commit      = imem_resp && load_pc;
    pc_en       = redirect || commit;
    pc_d        = redirect ? {redirect_pc[31:2], 2'b00} : req_addr + 32'd4;
    req_en      = state == IDLE && imem_read_i && !redirect;
    buf_en      = state == REQ && icache_resp && !load_pc && !redirect;
  end
  register #(.W(32), .RST_VAL(RESET_PC)) u_pc (.clk(clk), .rst(rst), .en(pc_en), .d(pc_d), .q(pc));
  register #(.W(32), .RST_VAL(RESET_PC)) u_req (.clk(clk), .rst(rst), .en(req_en), .d(pc), .q(req_addr));
  register #(.W(32), .RST_VAL('0)) u_buf (.clk(clk), .rst(rst), .en(buf_en), .d(icache_rdata), .q(instr_buf));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus randomized run against a transaction-level fetch model.
module tb_fetch_unit;
  logic clk = 0, rst = 1, imem_read_i = 0, load_pc = 0, redirect = 0, icache_resp = 0;
  logic [31:0] redirect_pc = 0, icache_rdata = 0;
  logic icache_read, imem_resp;
  logic [31:0] icache_addr, if_instr, if_pc;
  int n_chk = 0, n_fail = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_read_i(imem_read_i), .load_pc(load_pc), .redirect(redirect),
    .redirect_pc(redirect_pc), .icache_read(icache_read), .icache_addr(icache_addr),
    .icache_resp(icache_resp), .icache_rdata(icache_rdata), .imem_resp(imem_resp),
    .if_instr(if_instr), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, ird, ld, rd;
    logic [31:0] rpc;
    logic rsp;
    logic [31:0] rdat;
    logic e_rd;
    logic [31:0] e_addr;
    logic e_rsp;
    logic [31:0] e_ins, e_pc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic r, logic ird, logic ld, logic rd, logic [31:0] rpc, logic rsp,
                              logic [31:0] rdat, logic e_rd, logic [31:0] e_addr, logic e_rsp,
                              logic [31:0] e_ins, logic [31:0] e_pc);
    vec_t v;
    v.rst = r; v.ird = ird; v.ld = ld; v.rd = rd; v.rpc = rpc; v.rsp = rsp; v.rdat = rdat;
    v.e_rd = e_rd; v.e_addr = e_addr; v.e_rsp = e_rsp; v.e_ins = e_ins; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_rd, input logic [31:0] e_addr,
                            input logic e_rsp, input logic [31:0] e_ins, input logic [31:0] e_pc);
    chk({tag, ".icache_read"}, {31'b0, icache_read}, {31'b0, e_rd});
    if (e_rd) chk({tag, ".icache_addr"}, icache_addr, e_addr);
    chk({tag, ".imem_resp"}, {31'b0, imem_resp}, {31'b0, e_rsp});
    if (e_rsp) chk({tag, ".if_instr"}, if_instr, e_ins);
    chk({tag, ".if_pc"}, if_pc, e_pc);
  endtask

  localparam logic [31:0] P = 32'h4000_0000;
  localparam logic [31:0] I = 32'h00A0_0093;

  // transaction-level reference: PC, in-flight read (possibly squashed) and a held word
  logic [31:0] m_pc, m_addr, m_buf;
  logic m_req, m_squash, m_buf_v;
  int c_cnt, c_lat;

  initial begin
    // reset and back-to-back fetch with a 1-cycle cache
    tv.push_back(mk(0,0,0,0,0,0,0,          0,0,0,0,P));
    tv.push_back(mk(0,1,0,0,0,0,0,          0,0,0,0,P));
    tv.push_back(mk(0,1,1,0,0,1,32'hA1,     1,P,1,32'hA1,P));
    tv.push_back(mk(0,1,0,0,0,0,0,          0,0,0,0,P+4));
    tv.push_back(mk(0,0,1,0,0,1,32'hA2,     1,P+4,1,32'hA2,P+4));
    tv.push_back(mk(1,0,0,0,0,0,0,          0,0,0,0,P+8));
    // hold the word while load_pc stays low
    tv.push_back(mk(0,1,0,0,0,0,0,          0,0,0,0,P));
    tv.push_back(mk(0,1,0,0,0,1,I,          1,P,1,I,P));
    tv.push_back(mk(0,1,0,0,0,0,0,          0,0,1,I,P));
    tv.push_back(mk(0,1,0,0,0,0,0,          0,0,1,I,P));
    tv.push_back(mk(0,1,0,0,0,0,0,          0,0,1,I,P));
    tv.push_back(mk(0,1,1,0,0,0,0,          0,0,1,I,P));
    tv.push_back(mk(0,0,0,0,0,0,0,          0,0,0,0,P+4));
    tv.push_back(mk(1,0,0,0,0,0,0,          0,0,0,0,P+4));
    // redirect during REQ, late response is dropped
    tv.push_back(mk(0,1,0,0,0,0,0,          0,0,0,0,P));
    tv.push_back(mk(0,1,0,1,P+32'h102,0,0,  1,P,0,0,P));
    tv.push_back(mk(0,1,0,0,0,0,0,          1,P,0,0,P+32'h100));
    tv.push_back(mk(0,1,0,0,0,0,0,          1,P,0,0,P+32'h100));
    tv.push_back(mk(0,1,0,0,0,0,0,          1,P,0,0,P+32'h100));
    tv.push_back(mk(0,1,0,0,0,1,32'hDEAD,   1,P,0,0,P+32'h100));
    tv.push_back(mk(0,1,0,0,0,0,0,          0,0,0,0,P+32'h100));
    tv.push_back(mk(0,1,0,0,0,0,0,          1,P+32'h100,0,0,P+32'h100));
    // redirect together with resp and load_pc
    tv.push_back(mk(0,1,1,1,P+32'h200,1,32'h11, 1,P+32'h100,0,0,P+32'h100));
    tv.push_back(mk(0,0,0,0,0,0,0,          0,0,0,0,P+32'h200));
    // reset in DROP and in HOLD
    tv.push_back(mk(0,1,0,0,0,0,0,          0,0,0,0,P+32'h200));
    tv.push_back(mk(0,1,0,1,P+32'h300,0,0,  1,P+32'h200,0,0,P+32'h200));
    tv.push_back(mk(1,1,0,0,0,0,0,          1,P+32'h200,0,0,P+32'h300));
    tv.push_back(mk(0,0,0,0,0,0,0,          0,0,0,0,P));
    tv.push_back(mk(0,1,0,0,0,0,0,          0,0,0,0,P));
    tv.push_back(mk(0,1,0,0,0,1,32'h22,     1,P,1,32'h22,P));
    tv.push_back(mk(1,1,0,0,0,0,0,          0,0,1,32'h22,P));
    tv.push_back(mk(0,0,0,0,0,0,0,          0,0,0,0,P));
    // PC wrap at the top of the address space
    tv.push_back(mk(0,1,0,1,32'hFFFF_FFFE,0,0, 0,0,0,0,P));
    tv.push_back(mk(0,1,0,0,0,0,0,          0,0,0,0,32'hFFFF_FFFC));
    tv.push_back(mk(0,0,1,0,0,1,32'h33,     1,32'hFFFF_FFFC,1,32'h33,32'hFFFF_FFFC));
    tv.push_back(mk(0,0,0,0,0,0,0,          0,0,0,0,32'h0));

    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < tv.size(); i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      rst = tv[i].rst; imem_read_i = tv[i].ird; load_pc = tv[i].ld; redirect = tv[i].rd;
      redirect_pc = tv[i].rpc; icache_resp = tv[i].rsp; icache_rdata = tv[i].rdat;
      #3 check_outs($sformatf("vec%0d", i), tv[i].e_rd, tv[i].e_addr, tv[i].e_rsp, tv[i].e_ins, tv[i].e_pc);
    end

    // randomized run
    @(posedge clk);
    #1 rst = 1; imem_read_i = 0; load_pc = 0; redirect = 0; icache_resp = 0;
    @(posedge clk);
    #1 rst = 0;
    m_pc = P; m_addr = P; m_buf = 0; m_req = 0; m_squash = 0; m_buf_v = 0;
    c_cnt = 0; c_lat = 1;
    for (int i = 0; i < 3000; i++) begin
      logic e_rsp;
      logic [31:0] tgt;
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      rst = $urandom_range(199) == 0;
      imem_read_i = $urandom_range(3) != 0;
      load_pc = $urandom_range(2) != 0;
      redirect = $urandom_range(11) == 0;
      redirect_pc = $urandom_range(7) == 0 ? 32'hFFFF_FFFF : $urandom;
      #1;
      icache_resp = icache_read && (c_cnt + 1 >= c_lat);
      icache_rdata = $urandom;
      #2;
      e_rsp = !redirect && (m_buf_v || (m_req && !m_squash && icache_resp));
      check_outs("rand", m_req, m_addr, e_rsp, m_buf_v ? m_buf : icache_rdata,
                 (m_buf_v || (m_req && !m_squash)) ? m_addr : m_pc);
      if (icache_read) begin
        c_cnt = icache_resp ? 0 : c_cnt + 1;
        if (icache_resp) c_lat = $urandom_range(1, 4);
      end
      tgt = redirect_pc & ~32'd3;
      if (rst) begin
        m_pc = P; m_addr = P; m_buf = 0; m_req = 0; m_squash = 0; m_buf_v = 0; c_cnt = 0;
      end else if (redirect) begin
        m_pc = tgt;
        m_buf_v = 0;
        if (m_req && icache_resp) begin
          m_req = 0; m_squash = 0;
        end else if (m_req) m_squash = 1;
      end else if (m_buf_v) begin
        if (load_pc) begin
          m_pc = m_addr + 4; m_buf_v = 0;
        end
      end else if (m_req) begin
        if (icache_resp) begin
          m_req = 0;
          if (m_squash) m_squash = 0;
          else if (load_pc) m_pc = m_addr + 4;
          else begin
            m_buf_v = 1; m_buf = icache_rdata;
          end
        end
      end else if (imem_read_i) begin
        m_req = 1; m_addr = m_pc;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
